pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and instruction-fetch control stage of the multicycle RV32I core.
- Directly consumes the jal/branch/jalr targets produced by the branch address generator, plus the pc+4, mtvec and mepc sources.
- Selects and registers the next PC, and runs the instruction-memory fetch handshake.
- Holds the fetched instruction for decode until the control unit retires it with pc_write.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_source  in  3  next-PC select: 0=pc+4, 1=jalr, 2=branch, 3=jal, 4=mtvec, 5=mepc, 6/7=hold.
- pc_write  in  1  load the selected next PC this cycle.
- fetch_go  in  1  start an instruction fetch at the current pc.
- jalr, branch, jal  in  32 each  targets from the branch address generator.
- mtvec, mepc  in  32 each  trap vector and trap return address from the CSR file.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has returned the instruction this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc+4, for the rd writeback of JAL/JALR.
- ir  out  32  latched instruction.
- ir_valid  out  1  ir holds the instruction at the current pc.
- misalign_err  out  1  one-cycle pulse: a write was rejected because the target is misaligned.

Behaviour:
- Reset (async, any state): pc=RESET_VEC, state=IDLE, ir=0, ir_valid=0, imem_req=0, misalign_err=0. The request is dropped immediately, without waiting for a clock edge.
- Combinational outputs:
  - pc_plus4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
  - imem_addr = pc.
  - imem_req = 1 exactly while state==FETCH.
- Next-PC candidate, by pc_source:
  - jalr: target has bit 0 forced to 0 before use.
  - 6/7: candidate = pc; writes with these selects never raise an error.
- Misalignment: if the candidate's bits [1:0] != 0 on an accepted write, pc is not updated, misalign_err=1 for that one cycle, and state transitions proceed as if the write had succeeded.
- FSM states IDLE, FETCH, VALID:
  - IDLE:
    - fetch_go=1 -> FETCH.
    - pc_write=1 is accepted.
    - If both are asserted in the same cycle, pc updates at the edge and FETCH uses the new pc.
    - imem_ack is ignored (this discards a late ack after reset).
  - FETCH:
    - Wait for imem_ack. On ack, ir<=imem_rdata and ir_valid<=1 at that edge -> VALID. No timeout.
    - pc_write is ignored so pc stays stable during an outstanding request.
    - fetch_go is ignored.
  - VALID:
    - ir and ir_valid hold.
    - pc_write=1 is accepted: ir_valid<=0 -> IDLE.
    - fetch_go is ignored.
- Fetch latency: minimum 2 cycles from fetch_go to ir_valid (fetch_go edge, then ack edge).
- ir keeps its last value after ir_valid falls; only ir_valid qualifies it.
- misalign_err is registered; it is 0 in every cycle without a rejected write.

Test Plan:
- Reset and first fetch: assert rst mid-FETCH with RESET_VEC=0 -> imem_req falls immediately, pc=0, ir_valid=0. Release rst, fetch_go=1, imem_ack 3 cycles later with 32'h0000_0013 -> ir=0x13, ir_valid=1; pc_write with pc_source=0 -> pc=4, ir_valid=0, state IDLE.
- Source select: from VALID with pc=0x100, apply pc_write for each select:
  - jal=0x200 (source 3) -> pc=0x200.
  - branch=0x0FC (source 2) -> pc=0x0FC.
  - jalr=0x305 (source 1) -> pc=0x304.
  - mtvec=0x80 (source 4) -> pc=0x80.
  - mepc=0x44 (source 5) -> pc=0x44.
  - source 6 -> pc unchanged.
- Misalignment: branch=0x102 with pc_source=2 in VALID -> pc stays 0x100, misalign_err high for exactly one cycle, ir_valid=0. jalr=0x107 (source 1) -> target 0x106 -> rejected the same way.
- Write during FETCH: with pc=0x40 in FETCH, pulse pc_write with source 3, jal=0x80 -> pc stays 0x40, imem_addr=0x40. A later ack gives ir_valid=1.
- Simultaneous events in IDLE: fetch_go=1 and pc_write=1 with jal=0x500 (source 3) -> next cycle pc=0x500, imem_req=1, imem_addr=0x500. Separately, imem_ack pulsed while in IDLE -> ir and ir_valid unchanged.
- Wrap-around: drive pc to 0xFFFF_FFFC via mepc -> pc_plus4=0x0. pc_write with source 0 -> pc=0x0000_0000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch control for the multicycle RV32I core.
// Selects the next pc, runs the imem handshake and holds ir for decode.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_source,
    input  logic        pc_write,
    input  logic        fetch_go,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] jal,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] cand;
    logic        hold_sel;
    logic        wr_ok;
    logic        bad_tgt;
    logic        pc_load;
    logic        ir_load;
    logic        ir_clr;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);

    // Next-pc candidate mux; jalr drops bit 0, selects 6/7 hold pc.
    always_comb begin
        cand     = pc;
        hold_sel = 1'b0;
        unique case (pc_source)
            3'd0:    cand = pc_plus4;
            3'd1:    cand = {jalr[31:1], 1'b0};
            3'd2:    cand = branch;
            3'd3:    cand = jal;
            3'd4:    cand = mtvec;
            3'd5:    cand = mepc;
            default: hold_sel = 1'b1;
        endcase
    end

    // Write acceptance: writes are ignored while a fetch is outstanding.
    always_comb begin
        wr_ok   = pc_write && (state != FETCH);
        bad_tgt = wr_ok && !hold_sel && (cand[1:0] != 2'b00);
        pc_load = wr_ok && !bad_tgt;
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Fetch FSM next state and ir strobes; a rejected write still advances.
    always_comb begin
        state_nx = state;
        ir_load  = 1'b0;
        ir_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_go) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = VALID;
                end
            end
            VALID: begin
                if (pc_write) begin
                    ir_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else if (pc_load) begin
            pc <= cand;
        end
    end

    // Instruction register and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= 32'h0;
            ir_valid <= 1'b0;
        end else if (ir_load) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
        end else if (ir_clr) begin
            ir_valid <= 1'b0;
        end
    end

    // One-cycle pulse for a write rejected on a misaligned target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= bad_tgt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, fetch, source select,
// misalignment, writes during fetch, simultaneous events and wrap-around.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic        fetch_go;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, pc_plus4, ir;
    logic        ir_valid;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_source    (pc_source),
        .pc_write     (pc_write),
        .fetch_go     (fetch_go),
        .jalr         (jalr),
        .branch       (branch),
        .jal          (jal),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle 1ns past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // from IDLE: load addr and fetch it, ack next cycle -> VALID at addr
    task automatic load_valid(input logic [31:0] addr,
                              input logic [31:0] word);
        jal        = addr;
        pc_source  = 3'd3;
        pc_write   = 1'b1;
        fetch_go   = 1'b1;
        step();
        pc_write   = 1'b0;
        fetch_go   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
    endtask

    // single-cycle pc_write with the given source
    task automatic wr(input logic [2:0] src);
        pc_source = src;
        pc_write  = 1'b1;
        step();
        pc_write  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pc_source  = 3'd0;
        pc_write   = 1'b0;
        fetch_go   = 1'b0;
        jalr       = 32'h0;
        branch     = 32'h0;
        jal        = 32'h0;
        mtvec      = 32'h0;
        mepc       = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_irv", {31'h0, ir_valid}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);
        rst = 1'b0;

        // enter FETCH, then reset asynchronously mid-cycle
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("fetch_req", {31'h0, imem_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'h0, imem_req}, 32'h0);
        chk("async_pc", pc, 32'h0);
        chk("async_irv", {31'h0, ir_valid}, 32'h0);
        step();
        rst = 1'b0;

        // first fetch, ack three cycles after fetch_go
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("f1_addr", imem_addr, 32'h0);
        step();
        step();
        chk("f1_wait", {31'h0, ir_valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        step();
        imem_ack   = 1'b0;
        chk("f1_ir", ir, 32'h0000_0013);
        chk("f1_irv", {31'h0, ir_valid}, 32'h1);
        chk("f1_req", {31'h0, imem_req}, 32'h0);
        wr(3'd0);
        chk("f1_pc4", pc, 32'h4);
        chk("f1_irv0", {31'h0, ir_valid}, 32'h0);
        chk("f1_ir_keep", ir, 32'h0000_0013);
        chk("f1_p4", pc_plus4, 32'h8);

        // source select from VALID at 0x100
        load_valid(32'h100, 32'h1111_1111);
        chk("sel_pre", pc, 32'h100);
        chk("sel_irv", {31'h0, ir_valid}, 32'h1);
        jal = 32'h200;
        wr(3'd3);
        chk("sel_jal", pc, 32'h200);
        load_valid(32'h100, 32'h1);
        branch = 32'h0FC;
        wr(3'd2);
        chk("sel_br", pc, 32'h0FC);
        load_valid(32'h100, 32'h2);
        jalr = 32'h305;
        wr(3'd1);
        chk("sel_jalr", pc, 32'h304);
        chk("sel_jalr_err", {31'h0, misalign_err}, 32'h0);
        load_valid(32'h100, 32'h3);
        mtvec = 32'h80;
        wr(3'd4);
        chk("sel_mtvec", pc, 32'h80);
        load_valid(32'h100, 32'h4);
        mepc = 32'h44;
        wr(3'd5);
        chk("sel_mepc", pc, 32'h44);
        load_valid(32'h100, 32'h5);
        wr(3'd6);
        chk("sel_hold", pc, 32'h100);
        chk("sel_hold_err", {31'h0, misalign_err}, 32'h0);
        chk("sel_hold_irv", {31'h0, ir_valid}, 32'h0);

        // misaligned branch target
        load_valid(32'h100, 32'h6);
        branch = 32'h102;
        wr(3'd2);
        chk("mis_br_pc", pc, 32'h100);
        chk("mis_br_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_br_irv", {31'h0, ir_valid}, 32'h0);
        step();
        chk("mis_br_pulse", {31'h0, misalign_err}, 32'h0);

        // misaligned jalr target after bit-0 clear
        load_valid(32'h100, 32'h7);
        jalr = 32'h107;
        wr(3'd1);
        chk("mis_jr_pc", pc, 32'h100);
        chk("mis_jr_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_jr_irv", {31'h0, ir_valid}, 32'h0);
        step();
        chk("mis_jr_pulse", {31'h0, misalign_err}, 32'h0);

        // pc_write ignored during FETCH
        jal       = 32'h40;
        pc_source = 3'd3;
        pc_write  = 1'b1;
        fetch_go  = 1'b1;
        step();
        pc_write  = 1'b0;
        fetch_go  = 1'b0;
        chk("fw_pc0", pc, 32'h40);
        jal = 32'h80;
        wr(3'd3);
        chk("fw_pc", pc, 32'h40);
        chk("fw_addr", imem_addr, 32'h40);
        chk("fw_req", {31'h0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        chk("fw_irv", {31'h0, ir_valid}, 32'h1);
        chk("fw_ir", ir, 32'hDEAD_BEEF);
        wr(3'd6);
        chk("fw_idle_pc", pc, 32'h40);

        // simultaneous fetch_go and pc_write in IDLE
        jal       = 32'h500;
        pc_source = 3'd3;
        pc_write  = 1'b1;
        fetch_go  = 1'b1;
        step();
        pc_write  = 1'b0;
        fetch_go  = 1'b0;
        chk("sim_pc", pc, 32'h500);
        chk("sim_req", {31'h0, imem_req}, 32'h1);
        chk("sim_addr", imem_addr, 32'h500);
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_AAAA;
        step();
        imem_ack   = 1'b0;
        chk("sim_ir", ir, 32'hAAAA_AAAA);
        wr(3'd7);

        // stray ack in IDLE is ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_ack   = 1'b0;
        chk("ack_idle_ir", ir, 32'hAAAA_AAAA);
        chk("ack_idle_irv", {31'h0, ir_valid}, 32'h0);
        chk("ack_idle_req", {31'h0, imem_req}, 32'h0);

        // misaligned write in IDLE also pulses the error
        jal = 32'h501;
        wr(3'd3);
        chk("idle_mis_pc", pc, 32'h500);
        chk("idle_mis_err", {31'h0, misalign_err}, 32'h1);

        // wrap-around
        mepc = 32'hFFFF_FFFC;
        wr(3'd5);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        chk("wrap_err", {31'h0, misalign_err}, 32'h0);
        wr(3'd0);
        chk("wrap_pc0", pc, 32'h0);
        chk("wrap_p4b", pc_plus4, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
